// File: rtl/affine_seq_core.sv
// Programmable affine sequencer: DEPTH-entry program memory, 4xN register file, dual-write multiply-add.
// Define AFFINE_SAT_EN for unsigned saturation of the multiply-add result instead of modulo wrap.
module affine_seq_core #(
    parameter  int N      = 8,
    parameter  int DEPTH  = 16,
    localparam int A      = $clog2(DEPTH),
    localparam int W_INST = 2*N+10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              prog_we_i,
    input  logic [A-1:0]      prog_addr_i,
    input  logic [W_INST-1:0] prog_data_i,
    input  logic              start_i,
    input  logic [A-1:0]      len_i,
    input  logic              abort_i,
    input  logic [N-1:0]      ext_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [N-1:0]      ext_data_o,
    output logic [A-1:0]      pc_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state;
    logic [A-1:0]      pc;
    logic [A-1:0]      last_pc;
    logic [N-1:0]      regs [4];
    logic [W_INST-1:0] mem  [DEPTH];

    logic [W_INST-1:0] inst;
    logic              frac_c;
    logic              wdual;
    logic [1:0]        mul_a_sel;
    logic [1:0]        add_b_sel;
    logic [1:0]        rd;
    logic [1:0]        rs;
    logic [N-1:0]      imm1;
    logic [N-1:0]      imm2;
    logic [N-1:0]      op_a;
    logic [N-1:0]      op_b;
    logic [2*N-1:0]    product;
    logic [N-1:0]      m_term;
    logic [N:0]        sum;
    logic [N-1:0]      r1;
    logic              unused_bits;

    // NOTE: program memory is deliberately not reset, so a loaded program survives rst_i.
    always_ff @(posedge clk_i) begin
        if (prog_we_i && state != S_RUN)
            mem[prog_addr_i] <= prog_data_i;
    end

    always_comb begin
        inst      = mem[pc];
        frac_c    = inst[2*N+9];
        wdual     = inst[2*N+8];
        mul_a_sel = inst[2*N+7:2*N+6];
        add_b_sel = inst[2*N+5:2*N+4];
        rd        = inst[2*N+3:2*N+2];
        rs        = inst[2*N+1:2*N];
        imm1      = inst[2*N-1:N];
        imm2      = inst[N-1:0];

        case (mul_a_sel)
            2'd0:    op_a = regs[rs];
            2'd1:    op_a = regs[rd];
            2'd2:    op_a = imm1;
            default: op_a = regs[1];
        endcase

        case (add_b_sel)
            2'd0:    op_b = regs[rd];
            2'd1:    op_b = imm1;
            2'd2:    op_b = regs[2];
            default: op_b = '0;
        endcase

        product = {{N{1'b0}}, op_a} * {{N{1'b0}}, imm2};
        // Fractional mode treats the product as Q0.(N-1) and keeps the aligned N bits.
        m_term  = frac_c ? product[2*N-2:N-1] : product[N-1:0];
        sum     = {1'b0, m_term} + {1'b0, op_b};
`ifdef AFFINE_SAT_EN
        r1      = sum[N] ? '1 : sum[N-1:0];
`else
        r1      = sum[N-1:0];
`endif
    end

    assign unused_bits = ^{product[2*N-1], sum[N]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            pc      <= '0;
            last_pc <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            for (int i = 0; i < 4; i++)
                regs[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state   <= S_RUN;
                        busy_o  <= 1'b1;
                        pc      <= '0;
                        regs[0] <= ext_data_i;
                        // len 0 wraps to DEPTH-1, which selects the full program.
                        last_pc <= len_i - A'(1);
                    end
                end
                S_RUN: begin
                    if (abort_i) begin
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        if (wdual)
                            regs[2] <= regs[rs];
                        // NOTE: the later non-blocking write to the same register wins, so rd==2 overrides wdual.
                        if (rd != 2'd0)
                            regs[rd] <= r1;
                        pc <= pc + A'(1);
                        if (pc == last_pc) begin
                            state  <= S_DONE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

    assign ext_data_o = regs[1];
    assign pc_o       = pc;

endmodule

// File: tb/tb_affine_seq_core.sv
// Self-checking bench for affine_seq_core: directed cases plus random programs against an arithmetic model.
module tb_affine_seq_core;

    localparam int N     = 8;
    localparam int DEPTH = 16;
    localparam int A     = 4;
    localparam int W     = 2*N+10;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         prog_we_i;
    logic [A-1:0] prog_addr_i;
    logic [W-1:0] prog_data_i;
    logic         start_i;
    logic [A-1:0] len_i;
    logic         abort_i;
    logic [N-1:0] ext_data_i;
    logic         busy_o;
    logic         done_o;
    logic [N-1:0] ext_data_o;
    logic [A-1:0] pc_o;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] prog [DEPTH];
    int           m_r  [4];

    affine_seq_core #(.N(N), .DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .prog_we_i   (prog_we_i),
        .prog_addr_i (prog_addr_i),
        .prog_data_i (prog_data_i),
        .start_i     (start_i),
        .len_i       (len_i),
        .abort_i     (abort_i),
        .ext_data_i  (ext_data_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .ext_data_o  (ext_data_o),
        .pc_o        (pc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] enc(input int frac, input int wd, input int msel, input int bsel,
                                         input int rd, input int rs, input int i1, input int i2);
        logic [W-1:0] w;
        w        = '0;
        w[25]    = frac[0];
        w[24]    = wd[0];
        w[23:22] = msel[1:0];
        w[21:20] = bsel[1:0];
        w[19:18] = rd[1:0];
        w[17:16] = rs[1:0];
        w[15:8]  = i1[7:0];
        w[7:0]   = i2[7:0];
        return w;
    endfunction

    // Reference: one instruction applied to the model register file with plain integer arithmetic.
    task automatic model_exec(input logic [W-1:0] w);
        int old [4];
        int rd, rs, i1, i2, a, b, p, m, s, r1;
        old = m_r;
        rd  = int'(w[19:18]);
        rs  = int'(w[17:16]);
        i1  = int'(w[15:8]);
        i2  = int'(w[7:0]);
        case (int'(w[23:22]))
            0:       a = old[rs];
            1:       a = old[rd];
            2:       a = i1;
            default: a = old[1];
        endcase
        case (int'(w[21:20]))
            0:       b = old[rd];
            1:       b = i1;
            2:       b = old[2];
            default: b = 0;
        endcase
        p = a * i2;
        m = w[25] ? (p / 128) % 256 : p % 256;
        s = m + b;
`ifdef AFFINE_SAT_EN
        r1 = (s > 255) ? 255 : s;
`else
        r1 = s % 256;
`endif
        if (w[24])
            m_r[2] = old[rs];
        if (rd != 0)
            m_r[rd] = r1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load(input int addr, input logic [W-1:0] w);
        prog_we_i   = 1'b1;
        prog_addr_i = addr[A-1:0];
        prog_data_i = w;
        tick();
        prog_we_i   = 1'b0;
        prog[addr]  = w;
    endtask

    // Full run with per-cycle checks; disturb pokes start_i and a program write mid-run.
    task automatic run(input int len, input int sample, input bit disturb);
        int L;
        L          = (len == 0) ? DEPTH : len;
        ext_data_i = sample[N-1:0];
        len_i      = len[A-1:0];
        start_i    = 1'b1;
        tick();
        start_i    = 1'b0;
        m_r[0]     = sample;
        for (int k = 0; k < L; k++) begin
            check("busy_run", busy_o, 1);
            check("pc_run", pc_o, k);
            check("done_run", done_o, 0);
            if (disturb && k == 5) begin
                start_i     = 1'b1;
                prog_we_i   = 1'b1;
                prog_addr_i = 4'd12;
                prog_data_i = enc(0, 0, 2, 1, 1, 0, 'hA5, 0);
            end
            tick();
            start_i   = 1'b0;
            prog_we_i = 1'b0;
            model_exec(prog[k]);
            check("r1_step", ext_data_o, m_r[1]);
        end
        check("done_pulse", done_o, 1);
        check("busy_done", busy_o, 0);
        tick();
        check("done_clear", done_o, 0);
        check("busy_idle", busy_o, 0);
    endtask

    initial begin
        rst_i       = 1'b1;
        prog_we_i   = 1'b0;
        prog_addr_i = '0;
        prog_data_i = '0;
        start_i     = 1'b0;
        len_i       = '0;
        abort_i     = 1'b0;
        ext_data_i  = '0;
        for (int i = 0; i < 4; i++) m_r[i] = 0;
        #2;
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_pc", pc_o, 0);
        check("rst_ext", ext_data_o, 0);
        tick();
        rst_i = 1'b0;
        tick();

        // Basic multiply-add from the sampled input.
        load(0, enc(0, 0, 0, 1, 1, 0, 5, 3));
        run(1, 'h10, 0);
        check("t1_result", ext_data_o, 'h35);

        // Fractional product.
        load(0, enc(1, 0, 2, 3, 1, 0, 'h40, 'h40));
        run(1, 0, 0);
        check("t2_frac", ext_data_o, 'h20);

        // Overflow: wrap or saturate.
        load(0, enc(0, 0, 2, 1, 1, 0, 'hFF, 2));
        run(1, 0, 0);
`ifdef AFFINE_SAT_EN
        check("t3_sat", ext_data_o, 'hFF);
`else
        check("t3_wrap", ext_data_o, 'hFD);
`endif

        // wdual copies R[rs] into R2; back-to-back read of R2.
        load(0, enc(0, 1, 3, 3, 3, 0, 0, 0));
        load(1, enc(0, 0, 2, 2, 1, 0, 0, 0));
        run(2, 'h5A, 0);
        check("wdual_copy", ext_data_o, 'h5A);

        // rd==2 together with wdual: the result write wins.
        load(0, enc(0, 1, 2, 1, 2, 0, 'h11, 1));
        run(2, 'h77, 0);
        check("wdual_rd2", ext_data_o, 'h22);

        // len=0 runs all DEPTH entries; mid-run start and program write are ignored.
        for (int i = 0; i < DEPTH; i++) load(i, W'($urandom()));
        run(0, int'($urandom_range(0, 255)), 1);

        // Random programs of random length.
        for (int r = 0; r < 4; r++) begin
            int len;
            len = int'($urandom_range(1, DEPTH-1));
            for (int i = 0; i < len; i++) load(i, W'($urandom()));
            run(len, int'($urandom_range(0, 255)), 0);
        end

        // Abort during the third RUN cycle.
        load(0, enc(0, 0, 2, 1, 1, 0, 'h11, 0));
        load(1, enc(0, 0, 3, 1, 1, 0, 'h01, 1));
        load(2, enc(0, 0, 2, 1, 1, 0, 'h99, 0));
        ext_data_i = 8'h3C;
        len_i      = 4'd3;
        start_i    = 1'b1;
        tick();
        start_i    = 1'b0;
        m_r[0]     = 'h3C;
        tick();
        check("abort_i0", ext_data_o, 'h11);
        tick();
        check("abort_i1", ext_data_o, 'h12);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("abort_busy", busy_o, 0);
        check("abort_done", done_o, 0);
        check("abort_r1", ext_data_o, 'h12);
        tick();
        check("abort_nodone", done_o, 0);
        m_r[1] = 'h12;
        run(3, 'h3C, 0);
        check("abort_rerun", ext_data_o, 'h99);

        // Asynchronous reset mid-run; program memory survives.
        load(0, enc(0, 0, 0, 1, 1, 0, 5, 3));
        for (int i = 1; i < 4; i++) load(i, enc(0, 0, 2, 1, 3, 0, 'h33, 0));
        ext_data_i = 8'h10;
        len_i      = 4'd4;
        start_i    = 1'b1;
        tick();
        start_i    = 1'b0;
        tick();
        tick();
        check("pre_rst_r1", ext_data_o, 'h35);
        check("pre_rst_busy", busy_o, 1);
        #2;
        rst_i = 1'b1;
        #1;
        check("async_busy", busy_o, 0);
        check("async_done", done_o, 0);
        check("async_pc", pc_o, 0);
        check("async_ext", ext_data_o, 0);
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) m_r[i] = 0;
        tick();
        run(4, 'h10, 0);
        check("rerun_after_rst", ext_data_o, 'h35);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
